// File: rtl/poly_eval_horner.sv
// rtl/poly_eval_horner.sv - Horner polynomial evaluator loaded item by item from a go-strobed switch bus
// Coefficients a_D..a_0 then x are captured once per go press; re-evaluation with a new x is supported.
module poly_eval_horner #(
  parameter int WIDTH  = 8,
  parameter int DEGREE = 2
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            go,
  input  logic                            reeval,
  input  logic [WIDTH-1:0]                data_in,
  output logic [WIDTH-1:0]                data_result,
  output logic [$clog2(DEGREE+2)-1:0]     load_idx,
  output logic                            busy,
  output logic                            done,
  output logic                            overflow
);

  localparam int IW = $clog2(DEGREE + 2);
  localparam int KW = $clog2(DEGREE + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(DEGREE + 1);
  localparam logic [KW-1:0] LAST_K   = KW'(DEGREE);

  typedef enum logic [2:0] {
    S_LOAD,
    S_LOAD_WAIT,
    S_EVAL,
    S_HOLD,
    S_HOLD_WAIT
  } state_t;

  state_t state, state_next;

  logic [WIDTH-1:0]   coef [DEGREE+1];
  logic [WIDTH-1:0]   x;
  logic [WIDTH-1:0]   acc;
  logic [KW-1:0]      k;
  logic               mode_reeval;
  logic [WIDTH-1:0]   coef_k;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH:0]     sum;
  logic               step_ovf;
  logic               start_eval;

  always_comb begin
    coef_k = '0;
    for (int i = 0; i <= DEGREE; i++) begin
      if (k == KW'(i)) coef_k = coef[i];
    end
  end

  // Overflow looks at the full-width product and at the carry of the truncated sum.
  assign prod     = {{WIDTH{1'b0}}, acc} * {{WIDTH{1'b0}}, x};
  assign sum      = {1'b0, prod[WIDTH-1:0]} + {1'b0, coef_k};
  assign step_ovf = (|prod[2*WIDTH-1:WIDTH]) | sum[WIDTH];

  assign start_eval = !go && (((state == S_LOAD_WAIT) && (load_idx == LAST_IDX)) ||
                              ((state == S_HOLD_WAIT) && mode_reeval));
  assign busy = (state == S_EVAL);

  always_ff @(posedge clk) begin
    if (reset) state <= S_LOAD;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_LOAD:      if (go) state_next = S_LOAD_WAIT;
      S_LOAD_WAIT: if (!go) state_next = (load_idx == LAST_IDX) ? S_EVAL : S_LOAD;
      S_EVAL:      if (k == LAST_K) state_next = S_HOLD;
      S_HOLD:      if (go) state_next = S_HOLD_WAIT;
      S_HOLD_WAIT: if (!go) state_next = mode_reeval ? S_EVAL : S_LOAD;
      default:     state_next = S_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i <= DEGREE; i++) coef[i] <= '0;
      x           <= '0;
      acc         <= '0;
      k           <= '0;
      mode_reeval <= 1'b0;
      data_result <= '0;
      load_idx    <= '0;
      done        <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start_eval) begin
        acc      <= coef[0];
        k        <= KW'(1);
        overflow <= 1'b0;
      end
      case (state)
        S_LOAD: if (go) begin
          for (int i = 0; i <= DEGREE; i++) begin
            if (load_idx == IW'(i)) coef[i] <= data_in;
          end
          if (load_idx == LAST_IDX) x <= data_in;
        end
        S_LOAD_WAIT: if (!go && (load_idx != LAST_IDX)) load_idx <= load_idx + IW'(1);
        S_EVAL: begin
          acc <= sum[WIDTH-1:0];
          k   <= k + KW'(1);
          if (step_ovf) overflow <= 1'b1;
          if (k == LAST_K) begin
            data_result <= sum[WIDTH-1:0];
            done        <= 1'b1;
          end
        end
        S_HOLD: if (go) begin
          if (reeval) begin
            x           <= data_in;
            mode_reeval <= 1'b1;
          end else begin
            coef[0]     <= data_in;
            load_idx    <= '0;
            mode_reeval <= 1'b0;
          end
        end
        S_HOLD_WAIT: if (!go && !mode_reeval) load_idx <= IW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_poly_eval_horner.sv
// tb/tb_poly_eval_horner.sv - directed scoreboard bench for poly_eval_horner at 8-bit/deg-2 and 16-bit/deg-3
module tb_poly_eval_horner;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic        go8 = 1'b0, reeval8 = 1'b0;
  logic [7:0]  din8 = '0, res8;
  logic [1:0]  idx8;
  logic        busy8, done8, ovf8;

  logic        go16 = 1'b0, reeval16 = 1'b0;
  logic [15:0] din16 = '0, res16;
  logic [2:0]  idx16;
  logic        busy16, done16, ovf16;

  poly_eval_horner #(.WIDTH(8), .DEGREE(2)) dut8 (
    .clk(clk), .reset(reset), .go(go8), .reeval(reeval8), .data_in(din8),
    .data_result(res8), .load_idx(idx8), .busy(busy8), .done(done8), .overflow(ovf8));

  poly_eval_horner #(.WIDTH(16), .DEGREE(3)) dut16 (
    .clk(clk), .reset(reset), .go(go16), .reeval(reeval16), .data_in(din16),
    .data_result(res16), .load_idx(idx16), .busy(busy16), .done(done16), .overflow(ovf16));

  typedef struct {
    logic [15:0] res;
    logic        ovf;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  function automatic logic [15:0] o_res(input int sel);
    return (sel == 0) ? {8'h00, res8} : res16;
  endfunction
  function automatic int o_idx(input int sel);
    return (sel == 0) ? int'(idx8) : int'(idx16);
  endfunction
  function automatic logic o_busy(input int sel);
    return (sel == 0) ? busy8 : busy16;
  endfunction
  function automatic logic o_done(input int sel);
    return (sel == 0) ? done8 : done16;
  endfunction
  function automatic logic o_ovf(input int sel);
    return (sel == 0) ? ovf8 : ovf16;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input int sel, input logic g, input logic [15:0] d);
    if (sel == 0) begin go8 = g; din8 = d[7:0]; end
    else begin go16 = g; din16 = d; end
  endtask

  // Only the value present on the go rising cycle may be captured; later values are noise.
  task automatic press(input int sel, input logic [15:0] val, input int hold);
    @(negedge clk);
    set_in(sel, 1'b1, val);
    for (int i = 1; i < hold; i++) begin
      @(negedge clk);
      set_in(sel, 1'b1, 16'($urandom));
    end
    @(negedge clk);
    set_in(sel, 1'b0, 16'($urandom));
  endtask

  task automatic load_item(input int sel, input logic [15:0] val, input int hold, input int exp_idx);
    press(sel, val, hold);
    @(negedge clk);
    chk("load_idx_adv", 32'(o_idx(sel)), 32'(exp_idx));
  endtask

  task automatic run_eval(input int sel, input int deg, input logic [15:0] val, input int hold,
                          input logic [15:0] exp_res, input logic exp_ovf);
    int cnt = 0;
    int bcnt = 0;
    logic seen = 1'b0;
    exp_t e;
    sb.push_back('{res: exp_res, ovf: exp_ovf});
    press(sel, val, hold);
    while (cnt < 20 && !seen) begin
      @(negedge clk);
      cnt++;
      if (o_busy(sel)) bcnt++;
      if (o_done(sel)) seen = 1'b1;
    end
    e = sb.pop_front();
    chk("done_seen", 32'(seen), 32'd1);
    if (seen) begin
      chk("latency", 32'(cnt), 32'(deg + 1));
      chk("busy_cycles", 32'(bcnt), 32'(deg));
      chk("result", 32'(o_res(sel)), 32'(e.res));
      chk("overflow", 32'(o_ovf(sel)), 32'(e.ovf));
      @(negedge clk);
      chk("done_pulse_len", 32'(o_done(sel)), 32'd0);
      chk("hold_idx", 32'(o_idx(sel)), 32'(deg + 1));
    end
  endtask

  initial begin
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("rst_result8", 32'(res8), 32'd0);
    chk("rst_idx8", 32'(idx8), 32'd0);
    chk("rst_busy8", 32'(busy8), 32'd0);
    chk("rst_done8", 32'(done8), 32'd0);
    chk("rst_ovf8", 32'(ovf8), 32'd0);
    chk("rst_idx16", 32'(idx16), 32'd0);

    // 2x^2 + 3x + 4 at x=5
    load_item(0, 16'd2, 1, 1);
    load_item(0, 16'd3, 3, 2);
    load_item(0, 16'd4, 2, 3);
    run_eval(0, 2, 16'd5, 1, 16'd69, 1'b0);

    reeval8 = 1'b1;
    run_eval(0, 2, 16'd1, 2, 16'd9, 1'b0);

    // Full reload with long holds and noisy data_in; result must not move until done.
    reeval8 = 1'b0;
    load_item(0, 16'd1, 50, 1);
    chk("result_held_load", 32'(res8), 32'd9);
    load_item(0, 16'd0, 50, 2);
    load_item(0, 16'd0, 50, 3);
    chk("result_held_load2", 32'(res8), 32'd9);
    run_eval(0, 2, 16'd16, 50, 16'd0, 1'b1);

    reeval8 = 1'b1;
    run_eval(0, 2, 16'd2, 1, 16'd4, 1'b0);

    // Reset during the first eval cycle discards the evaluation.
    reeval8 = 1'b0;
    load_item(0, 16'd2, 1, 1);
    load_item(0, 16'd3, 1, 2);
    load_item(0, 16'd4, 1, 3);
    press(0, 16'd5, 1);
    @(negedge clk);
    chk("eval_cycle1_busy", 32'(busy8), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst_result", 32'(res8), 32'd0);
    chk("midrst_idx", 32'(idx8), 32'd0);
    chk("midrst_busy", 32'(busy8), 32'd0);
    chk("midrst_done", 32'(done8), 32'd0);
    chk("midrst_ovf", 32'(ovf8), 32'd0);
    begin
      int dcnt = 0;
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        if (done8) dcnt++;
      end
      chk("midrst_no_done", 32'(dcnt), 32'd0);
    end
    // 3x^2 + 0x + 1 at x=7
    load_item(0, 16'd3, 1, 1);
    load_item(0, 16'd0, 1, 2);
    load_item(0, 16'd1, 1, 3);
    run_eval(0, 2, 16'd7, 1, 16'd148, 1'b0);

    // 16-bit, degree 3: x^3 + 2x^2 + 3x + 4 at x=10
    load_item(1, 16'd1, 1, 1);
    load_item(1, 16'd2, 1, 2);
    load_item(1, 16'd3, 1, 3);
    load_item(1, 16'd4, 1, 4);
    run_eval(1, 3, 16'd10, 1, 16'd1234, 1'b0);

    // Reload from hold: first press is a_3. x^3 + 7 at x=256 wraps and overflows.
    reeval16 = 1'b0;
    load_item(1, 16'd1, 4, 1);
    chk("result_held_reload16", 32'(res16), 32'd1234);
    load_item(1, 16'd0, 1, 2);
    load_item(1, 16'd0, 1, 3);
    load_item(1, 16'd7, 1, 4);
    run_eval(1, 3, 16'd256, 1, 16'd7, 1'b1);

    reeval16 = 1'b1;
    run_eval(1, 3, 16'd3, 1, 16'd34, 1'b0);

    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/poly_eval_horner.md
Name: poly_eval_horner

Overview:
- Parametrised polynomial evaluator: y = a_D·x^D + … + a_1·x + a_0, with D = DEGREE, arithmetic modulo 2^WIDTH.
- Coefficients and x are loaded one value per go press/release from a switch bus. Evaluation uses Horner's method, one multiply-add per cycle.
- Adds a sticky overflow flag, busy/done status, and re-evaluation with a new x without reloading coefficients.
- Sits between the board top (switches/KEY/HEX) and display logic, in the same role as the existing fixed quadratic datapath/control pair.

Parameters:
- WIDTH, 8: data width of coefficients, x, accumulator and result.
- DEGREE, 2: polynomial degree D (≥1); D+1 coefficients are stored.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high; clears all state on the next rising edge of clk.
- go  in  1  level, active-high (already debounced/inverted by top); one press+release = one load/start.
- reeval  in  1  sampled with go rising in S_HOLD: 1 = new x only, 0 = full reload.
- data_in  in  WIDTH  value captured on load.
- data_result  out  WIDTH  last evaluated y; holds until next completed evaluation.
- load_idx  out  clog2(DEGREE+2)  item awaited: 0..D = a_D..a_0, D+1 = x.
- busy  out  1  high in S_EVAL.
- done  out  1  one-cycle pulse on the cycle data_result updates.
- overflow  out  1  sticky for the last evaluation; valid with done.

Behaviour:
- Reset values: data_result=0, load_idx=0, busy=0, done=0, overflow=0; coef regs, x, acc=0; state=S_LOAD.
- Reset has priority over every other event, including reset mid-load or mid-eval. An in-flight eval is discarded with no done pulse.
- States: S_LOAD, S_LOAD_WAIT, S_EVAL, S_HOLD, S_HOLD_WAIT.
- S_LOAD:
  - go=1 → capture data_in into item load_idx (coef[load_idx] for idx≤D, else x); go to S_LOAD_WAIT.
  - Capture happens once per press.
- S_LOAD_WAIT:
  - Stay while go=1; data_in changes are ignored.
  - On go=0: if load_idx<D+1 → load_idx++, S_LOAD.
  - If load_idx=D+1 → acc←coef[0] (a_D), k←1, overflow←0, S_EVAL.
- S_EVAL (busy=1, go ignored):
  - Each cycle acc ← acc·x + coef[k] (mod 2^WIDTH); k++.
  - Exactly DEGREE cycles.
  - On the last cycle data_result ← result and done=1 in the following cycle; next state S_HOLD.
  - Latency: DEGREE+1 cycles from go release to done.
- Overflow: set if any full-precision product acc·x (2·WIDTH bits) or sum ≥ 2^WIDTH, in any step. Cleared only at eval start or reset.
- S_HOLD: outputs held, load_idx=D+1.
  - go=1 with reeval=1 → x←data_in, S_HOLD_WAIT (mode=reeval).
  - go=1 with reeval=0 → coef[0]←data_in, load_idx←0, S_HOLD_WAIT (mode=reload).
- S_HOLD_WAIT: on go=0:
  - mode=reeval → start eval as above.
  - mode=reload → load_idx←1, S_LOAD.
- Go held arbitrarily long: no extra captures. A go glitch of one cycle counts as a press.
- data_result is not modified during load or hold; it changes only with done.

Test Plan:
- WIDTH=8, DEGREE=2; load a=2, b=3, c=4, x=5 → done pulse exactly 3 cycles after final release; data_result=0x45 (69); overflow=0; busy high 2 cycles.
- From S_HOLD, reeval=1, press with data_in=1 → data_result=9, coefficients unchanged, load_idx stays 3.
- Load 1, 0, 0, x=16 → data_result=0x00, overflow=1. A following reeval with x=2 → data_result=4, overflow=0.
- Hold go for 50 cycles while changing data_in per load → only the value present on the go rising cycle is captured; load_idx advances once per release.
- Assert reset during S_EVAL cycle 1 → next cycle all outputs zero, no done pulse, load_idx=0. A fresh load afterwards evaluates correctly.
- WIDTH=16, DEGREE=3; coefs 1, 2, 3, 4, x=10 → data_result=1234 (0x04D2), latency 4 cycles, overflow=0. From S_HOLD with reeval=0, the first press captures a_3 and the full reload works.
